// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection over a shadow EX/MEM/WB pipeline, with optional operand forwarding
// Ports: clk, rst_n (sync active-low); id_valid/id_rs1/id_rs2/id_uses_rs2/id_rd/id_reg_write_en describe the decode instruction;
//        stall/bubble hold decode and squash ID/EX; fwd_sel_a/fwd_sel_b pick operand source (01 EX, 10 MEM, 11 WB);
//        stall_count is a saturating count of stall cycles.
// Macro PIPE_HAZARD_CTRL_FORWARD_EN: forward from the shadow slots instead of stalling.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write_en,
  output logic        stall,
  output logic        bubble,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic [15:0] stall_count
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
  } slot_t;
  typedef enum logic {RUN, STALL} state_t;
  slot_t ex, mem, wb;
  state_t state;
  logic [2:0] hit_a, hit_b;
  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.v && s.we && s.rd != 5'd0 && s.rd == rs;
  endfunction
  always_comb begin
    hit_a = {hit(wb, id_rs1), hit(mem, id_rs1), hit(ex, id_rs1)} & {3{id_valid}};
    hit_b = {hit(wb, id_rs2), hit(mem, id_rs2), hit(ex, id_rs2)} & {3{id_valid & id_uses_rs2}};
`ifdef PIPE_HAZARD_CTRL_FORWARD_EN
    stall = 1'b0;
    // youngest producer wins: EX over MEM over WB
    fwd_sel_a = hit_a[0] ? 2'b01 : hit_a[1] ? 2'b10 : hit_a[2] ? 2'b11 : 2'b00;
    fwd_sel_b = hit_b[0] ? 2'b01 : hit_b[1] ? 2'b10 : hit_b[2] ? 2'b11 : 2'b00;
`else
    // register file is not write-through, so even a WB producer must drain
    stall = |{hit_a, hit_b};
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
`endif
    bubble = stall;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
      state <= RUN;
      stall_count <= '0;
    end else begin
      wb <= mem;
      mem <= ex;
      ex <= stall ? slot_t'(0) : slot_t'({id_valid, id_rd, id_reg_write_en});
      case (state)
        RUN: if (stall) begin
          state <= STALL;
          stall_count <= stall_count + {15'd0, ~&stall_count};
        end
        default: if (stall) stall_count <= stall_count + {15'd0, ~&stall_count};
                 else state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: randomized scoreboard bench for pipe_hazard_ctrl against a register-age reference model
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs2, id_reg_write_en;
  logic        stall, bubble;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_count;
  typedef struct packed {
    logic        st;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_write[32];
  int cnt_model = 0;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_reg_write_en(id_reg_write_en),
    .stall(stall), .bubble(bubble), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  // Reference: a read is hazardous when its register was last written by an instruction issued 1..3 cycles ago
  // (1 = EX, 2 = MEM, 3 = WB); the most recent writer is the one that matters.
  function automatic logic [1:0] age(input logic en, input logic [4:0] r);
    int d;
    if (!en || r == 5'd0) return 2'b00;
    d = cyc - last_write[r];
    return (d >= 1 && d <= 3) ? 2'(d) : 2'b00;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 32; i++) last_write[i] = -1000;
    cnt_model = 0;
  endtask
  task automatic step(input logic v, input logic [4:0] a, input logic [4:0] b, input logic u,
                      input logic [4:0] d, input logic w, input logic r, output logic st);
    exp_t e;
    logic [1:0] aa, ab;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = a; id_rs2 = b; id_uses_rs2 = u; id_rd = d; id_reg_write_en = w; rst_n = r;
    aa = age(v, a);
    ab = age(v & u, b);
`ifdef PIPE_HAZARD_CTRL_FORWARD_EN
    st = 1'b0;
    e = '{st: 1'b0, fa: aa, fb: ab, cnt: 16'(cnt_model)};
`else
    st = (aa != 2'b00) || (ab != 2'b00);
    e = '{st: st, fa: 2'b00, fb: 2'b00, cnt: 16'(cnt_model)};
`endif
    exp_q.push_back(e);
    if (!r) clear_model();
    else if (st) cnt_model = (cnt_model == 65535) ? 65535 : cnt_model + 1;
    else if (v && w) last_write[d] = cyc;
    cyc++;
  endtask
  // Decode holds the instruction until it is no longer stalled
  task automatic issue(input logic v, input logic [4:0] a, input logic [4:0] b, input logic u,
                       input logic [4:0] d, input logic w);
    logic st;
    for (int k = 0; k < 8; k++) begin
      step(v, a, b, u, d, w, 1'b1, st);
      if (!st) break;
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (stall !== e.st || bubble !== e.st) begin
        errors++;
        $display("FAIL stall/bubble cyc=%0d: got stall=%b bubble=%b, want %b", cyc, stall, bubble, e.st);
      end
      checks++;
      if (fwd_sel_a !== e.fa || fwd_sel_b !== e.fb) begin
        errors++;
        $display("FAIL fwd_sel cyc=%0d: got a=%b b=%b, want a=%b b=%b", cyc, fwd_sel_a, fwd_sel_b, e.fa, e.fb);
      end
      checks++;
      if (stall_count !== e.cnt) begin
        errors++;
        $display("FAIL stall_count cyc=%0d: got %0d, want %0d", cyc, stall_count, e.cnt);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic st;
    clear_model();
    rst_n = 1'b0;
    id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_uses_rs2 = 1'($urandom); id_rd = 5'($urandom); id_reg_write_en = 1'($urandom);
    step(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b0, st);
    issue(1, 1, 2, 1, 5, 1);
    issue(1, 5, 1, 1, 6, 1);
    issue(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    issue(1, 1, 2, 1, 0, 1);
    issue(1, 0, 0, 1, 7, 1);
    issue(1, 1, 2, 1, 9, 1);
    issue(1, 10, 9, 0, 8, 1);
    issue(1, 1, 2, 1, 9, 1);
    issue(1, 9, 9, 0, 8, 1);
    issue(1, 1, 2, 1, 3, 1);
    issue(1, 1, 2, 1, 3, 1);
    issue(1, 3, 3, 1, 4, 1);
    issue(1, 1, 2, 1, 3, 1);
    issue(1, 1, 2, 1, 11, 1);
    issue(1, 1, 2, 1, 12, 1);
    issue(1, 3, 3, 1, 4, 1);
    issue(1, 1, 2, 1, 5, 1);
    step(1, 5, 1, 1, 6, 1, 1'b1, st);
    step(1, 5, 1, 1, 6, 1, 1'b0, st);
    issue(1, 5, 1, 1, 6, 1);
    issue(1, 1, 2, 1, 13, 0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0)
        step(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b0, st);
      else
        issue($urandom_range(7) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom),
              5'($urandom_range(7)), $urandom_range(3) != 0);
    end
`ifdef PIPE_HAZARD_CTRL_FORWARD_EN
    for (int n = 0; n < 200; n++) issue(1, 5, 5, 1, 5, 1);
`else
    for (int n = 0; n < 21900; n++) issue(1, 5, 5, 1, 5, 1);
`endif
    issue(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
